// File: rtl/runner_pkg.sv
// Shared constants and types for the Tiny Runner player controller.
// Geometry is in screen rows, speeds in rows per frame.
package runner_pkg;

    localparam int GROUND_Y        = 400;
    localparam int HALF_H_STAND    = 50;
    localparam int HALF_H_CROUCH   = 25;
    localparam int JUMP_SPEED      = 20;
    localparam int GRAVITY         = 2;
    localparam int BEEP_FRAMES     = 6;
    localparam int HI_HALF_PER_DEF = 50000;
    localparam int LO_HALF_PER_DEF = 500000;

    localparam logic [9:0] Y_STAND   = 10'(GROUND_Y - HALF_H_STAND);
    localparam logic [9:0] Y_CROUCH  = 10'(GROUND_Y - HALF_H_CROUCH);
    localparam logic [9:0] HH_STAND  = 10'(HALF_H_STAND);
    localparam logic [9:0] HH_CROUCH = 10'(HALF_H_CROUCH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_JUMP   = 2'd1,
        ST_CROUCH = 2'd2,
        ST_DEAD   = 2'd3
    } state_e;

endpackage

// File: rtl/runner_player_ctrl_if.sv
// Player controller bus: gamepad/renderer inputs and player/game outputs.
// master = stimulus side (gamepad, renderer), slave = the controller.
interface runner_player_ctrl_if;
    import runner_pkg::*;

    logic        frame_tick;
    logic        btn_jump;
    logic        btn_crouch;
    logic        btn_start;
    logic        hit;
    logic [9:0]  player_y;
    logic [9:0]  player_hh;
    state_e      state;
    logic [15:0] score;
    logic        sound;

    modport master (
        output frame_tick, btn_jump, btn_crouch, btn_start, hit,
        input  player_y, player_hh, state, score, sound
    );

    modport slave (
        input  frame_tick, btn_jump, btn_crouch, btn_start, hit,
        output player_y, player_hh, state, score, sound
    );

endinterface

// File: rtl/runner_tone_gen.sv
// Square-wave beep generator: toggles sound every half-period while the beep is on.
// period_sel_i = 0 selects the high (jump) tone, 1 the low (death) tone.
module runner_tone_gen
    import runner_pkg::*;
#(
    parameter int HI_HALF_PER = HI_HALF_PER_DEF,
    parameter int LO_HALF_PER = LO_HALF_PER_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic beep_on_i,
    input  logic period_sel_i,
    output logic sound_o
);

    localparam int MAX_PER = (HI_HALF_PER > LO_HALF_PER) ? HI_HALF_PER : LO_HALF_PER;
    localparam int CNT_W   = (MAX_PER > 1) ? $clog2(MAX_PER) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;
    logic             sound_q, sound_d;

    always_comb begin
        last_cnt = period_sel_i ? CNT_W'(LO_HALF_PER - 1) : CNT_W'(HI_HALF_PER - 1);
        cnt_d    = cnt_q;
        sound_d  = sound_q;
        if (!beep_on_i) begin
            cnt_d   = '0;
            sound_d = 1'b0;
        // >= keeps the counter bounded if the period shrinks mid-beep
        end else if (cnt_q >= last_cnt) begin
            cnt_d   = '0;
            sound_d = ~sound_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            sound_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sound_q <= sound_d;
        end
    end

    assign sound_o = sound_q;

endmodule

// File: rtl/runner_player_ctrl.sv
// Tiny Runner frame-rate sequencer: player FSM, jump physics, score and beep control.
// Define RUNNER_DOUBLE_JUMP_EN to allow one extra mid-air jump per flight.
module runner_player_ctrl
    import runner_pkg::*;
#(
    parameter int HI_HALF_PER = HI_HALF_PER_DEF,
    parameter int LO_HALF_PER = LO_HALF_PER_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    runner_player_ctrl_if.slave  bus
);

    localparam logic signed [10:0] VY_JUMP  = 11'(JUMP_SPEED);
    localparam logic signed [10:0] VY_GRAV  = 11'(GRAVITY);
    localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y);
    localparam logic [2:0]         BEEP_LEN = 3'(BEEP_FRAMES);

    state_e             state_q;
    logic [9:0]         y_q;
    logic [9:0]         hh_q;
    logic signed [10:0] vy_q;
    logic [15:0]        score_q;
    logic               hit_lat_q;
    logic [2:0]         beep_cnt_q;
    logic               beep_lo_q;

    logic               hit_now;
    logic               dbl_fire;
    logic signed [11:0] y_fall;
    logic signed [11:0] bottom;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A hit may land on the tick cycle itself, so it joins the latched flag here
    assign hit_now = hit_lat_q | bus.hit;
    assign y_fall  = $signed({2'b00, y_q}) - {vy_q[10], vy_q};
    assign bottom  = y_fall + $signed({2'b00, hh_q});

`ifdef RUNNER_DOUBLE_JUMP_EN
    logic jump_prev_q;
    logic dbl_used_q;

    assign dbl_fire = (state_q == ST_JUMP) && !hit_now && !dbl_used_q &&
                      (vy_q <= 11'sd0) && bus.btn_jump && !jump_prev_q;

    // The extra jump is re-armed whenever the player is not airborne
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_prev_q <= 1'b0;
            dbl_used_q  <= 1'b0;
        end else if (bus.frame_tick) begin
            jump_prev_q <= bus.btn_jump;
            if (dbl_fire)
                dbl_used_q <= 1'b1;
            else if (state_q != ST_JUMP)
                dbl_used_q <= 1'b0;
        end
    end
`else
    assign dbl_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            y_q        <= Y_STAND;
            hh_q       <= HH_STAND;
            vy_q       <= '0;
            score_q    <= '0;
            hit_lat_q  <= 1'b0;
            beep_cnt_q <= '0;
            beep_lo_q  <= 1'b0;
        end else if (bus.frame_tick) begin
            hit_lat_q <= 1'b0;
            if (beep_cnt_q != 3'd0)
                beep_cnt_q <= beep_cnt_q - 3'd1;

            if (state_q == ST_DEAD) begin
                if (!hit_now && bus.btn_start) begin
                    state_q    <= ST_RUN;
                    y_q        <= Y_STAND;
                    hh_q       <= HH_STAND;
                    vy_q       <= '0;
                    score_q    <= '0;
                    beep_cnt_q <= '0;
                    beep_lo_q  <= 1'b0;
                end
            end else if (hit_now) begin
                state_q    <= ST_DEAD;
                beep_cnt_q <= BEEP_LEN;
                beep_lo_q  <= 1'b1;
            end else begin
                score_q <= sat_inc16(score_q);
                case (state_q)
                    ST_RUN: begin
                        if (bus.btn_jump) begin
                            state_q    <= ST_JUMP;
                            vy_q       <= VY_JUMP;
                            beep_cnt_q <= BEEP_LEN;
                            beep_lo_q  <= 1'b0;
                        end else if (bus.btn_crouch) begin
                            state_q <= ST_CROUCH;
                            y_q     <= Y_CROUCH;
                            hh_q    <= HH_CROUCH;
                        end
                    end
                    ST_JUMP: begin
                        if (dbl_fire) begin
                            vy_q       <= VY_JUMP;
                            beep_cnt_q <= BEEP_LEN;
                            beep_lo_q  <= 1'b0;
                        end else if (bottom >= GROUND_S) begin
                            state_q <= ST_RUN;
                            y_q     <= Y_STAND;
                            vy_q    <= '0;
                        end else begin
                            y_q  <= y_fall[9:0];
                            vy_q <= vy_q - VY_GRAV;
                        end
                    end
                    ST_CROUCH: begin
                        if (!bus.btn_crouch) begin
                            state_q <= ST_RUN;
                            y_q     <= Y_STAND;
                            hh_q    <= HH_STAND;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (bus.hit) begin
            hit_lat_q <= 1'b1;
        end
    end

    runner_tone_gen #(
        .HI_HALF_PER (HI_HALF_PER),
        .LO_HALF_PER (LO_HALF_PER)
    ) u_tone (
        .clk          (clk),
        .reset        (reset),
        .beep_on_i    (beep_cnt_q != 3'd0),
        .period_sel_i (beep_lo_q),
        .sound_o      (bus.sound)
    );

    assign bus.player_y  = y_q;
    assign bus.player_hh = hh_q;
    assign bus.state     = state_q;
    assign bus.score     = score_q;

endmodule

// File: tb/tb_runner_player_ctrl.sv
// Self-checking bench for runner_player_ctrl: vector table, directed corner sequences,
// and randomized frames against a closed-form behavioural model.
module tb_runner_player_ctrl;
    import runner_pkg::*;

    localparam int HI  = 4;
    localparam int LO  = 7;
    localparam int GAP = 24;

    logic clk = 1'b0;
    logic reset;

    runner_player_ctrl_if bus();

    runner_player_ctrl #(
        .HI_HALF_PER (HI),
        .LO_HALF_PER (LO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state for the randomized phase
    int m_st, m_y, m_hh, m_score, m_k, m_base;
    bit m_jprev, m_used;

    typedef struct {
        bit         j;
        bit         c;
        bit         s;
        logic [1:0] st;
        int         y;
        int         hh;
        int         sc;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int st, input int y, input int hh, input int sc);
        check({tag, ".state"}, 32'(bus.state), st);
        check({tag, ".y"}, 32'(bus.player_y), y);
        check({tag, ".hh"}, 32'(bus.player_hh), hh);
        check({tag, ".score"}, 32'(bus.score), sc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.btn_jump   = 1'b0;
        bus.btn_crouch = 1'b0;
        bus.btn_start  = 1'b0;
        bus.hit        = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One frame of gap cycles; tick on the last cycle; returns at the negedge after the tick edge
    task automatic run_frame(input bit j, input bit c, input bit s, input bit hm, input bit ht,
                             input int gap);
        bus.btn_jump   = j;
        bus.btn_crouch = c;
        bus.btn_start  = s;
        for (int i = 0; i < gap - 1; i++) begin
            bus.frame_tick = 1'b0;
            bus.hit        = hm && (i == (gap - 1) / 2);
            @(negedge clk);
        end
        bus.frame_tick = 1'b1;
        bus.hit        = ht;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.hit        = 1'b0;
    endtask

    // Called at the negedge after the beep-starting tick edge (n = 0)
    task automatic tone_check(input string name, input int per, input int n_last, input bit ticks);
        int exp;
        for (int n = 0; n <= n_last; n++) begin
            exp = (n >= 1 && (!ticks || n <= BEEP_FRAMES * GAP)) ? ((n / per) % 2) : 0;
            check(name, 32'(bus.sound), exp);
            bus.frame_tick = ticks && ((n + 1) % GAP == 0);
            @(negedge clk);
        end
        bus.frame_tick = 1'b0;
    endtask

    function automatic int jump_y(input int base, input int k);
        return base - (JUMP_SPEED * k - GRAVITY * k * (k - 1) / 2);
    endfunction

    task automatic model_reset();
        m_st    = 0;
        m_y     = GROUND_Y - HALF_H_STAND;
        m_hh    = HALF_H_STAND;
        m_score = 0;
        m_k     = 0;
        m_base  = m_y;
        m_used  = 1'b0;
    endtask

    task automatic model_tick(input bit j, input bit c, input bit s, input bit h);
        if (m_st == 3) begin
            if (!h && s) model_reset();
        end else if (h) begin
            m_st = 3;
        end else begin
            if (m_score < 65535) m_score++;
            case (m_st)
                0: begin
                    if (j) begin
                        m_st   = 1;
                        m_k    = 0;
                        m_base = m_y;
                    end else if (c) begin
                        m_st = 2;
                        m_y  = GROUND_Y - HALF_H_CROUCH;
                        m_hh = HALF_H_CROUCH;
                    end
                end
                1: begin
`ifdef RUNNER_DOUBLE_JUMP_EN
                    if (!m_used && m_k >= JUMP_SPEED / GRAVITY && j && !m_jprev) begin
                        m_used = 1'b1;
                        m_base = m_y;
                        m_k    = 0;
                    end else
`endif
                    begin
                        m_k++;
                        m_y = jump_y(m_base, m_k);
                        if (m_y + m_hh >= GROUND_Y) begin
                            m_y    = GROUND_Y - HALF_H_STAND;
                            m_st   = 0;
                            m_used = 1'b0;
                        end
                    end
                end
                2: begin
                    if (!c) begin
                        m_st = 0;
                        m_y  = GROUND_Y - HALF_H_STAND;
                        m_hh = HALF_H_STAND;
                    end
                end
                default: ;
            endcase
        end
        m_jprev = j;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        int ey;
        bit jb;

        tbl[0]  = '{0, 0, 0, 2'd0, 350, 50, 1};
        tbl[1]  = '{0, 0, 0, 2'd0, 350, 50, 2};
        tbl[2]  = '{0, 0, 0, 2'd0, 350, 50, 3};
        tbl[3]  = '{0, 1, 0, 2'd2, 375, 25, 4};
        tbl[4]  = '{0, 1, 0, 2'd2, 375, 25, 5};
        tbl[5]  = '{1, 1, 0, 2'd2, 375, 25, 6};
        tbl[6]  = '{0, 0, 0, 2'd0, 350, 50, 7};
        tbl[7]  = '{1, 1, 0, 2'd1, 350, 50, 8};
        tbl[8]  = '{1, 0, 0, 2'd1, 330, 50, 9};
        tbl[9]  = '{0, 0, 0, 2'd1, 312, 50, 10};
        tbl[10] = '{0, 1, 0, 2'd1, 296, 50, 11};

        // Power-on reset values, checked while reset is held
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.btn_jump   = 1'b0;
        bus.btn_crouch = 1'b0;
        bus.btn_start  = 1'b0;
        bus.hit        = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("reset", 0, 350, 50, 0);
        check("reset.sound", 32'(bus.sound), 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_frame(tbl[i].j, tbl[i].c, tbl[i].s, 1'b0, 1'b0, 4);
            chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].y, tbl[i].hh, tbl[i].sc);
            if (i == 2) check("vec2.sound", 32'(bus.sound), 0);
        end

        // Rest of the flight started by vec7 (3 airborne ticks done)
        sc = 11;
`ifdef RUNNER_DOUBLE_JUMP_EN
        for (int k = 4; k <= 10; k++) begin
            run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
            sc++;
            chk_out($sformatf("fly%0d", k), 1, jump_y(350, k), 50, sc);
        end
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        sc++;
        chk_out("dbl_fire", 1, 240, 50, sc);
        tone_check("dbl_beep", HI, 2 * HI + 1, 1'b0);
        for (int k2 = 1; k2 <= 26; k2++) begin
            jb = (k2 >= 12 && k2 <= 13);
            run_frame(jb, 1'b0, 1'b0, 1'b0, 1'b0, 4);
            sc++;
            ey = jump_y(240, k2);
            if (ey + 50 >= GROUND_Y) chk_out($sformatf("dfly%0d", k2), 0, 350, 50, sc);
            else                     chk_out($sformatf("dfly%0d", k2), 1, ey, 50, sc);
        end
`else
        for (int k = 4; k <= 21; k++) begin
            jb = (k == 11 || k == 12);
            run_frame(jb, 1'b0, 1'b0, 1'b0, 1'b0, 4);
            sc++;
            if (k < 21) chk_out($sformatf("fly%0d", k), 1, jump_y(350, k), 50, sc);
            else        chk_out("land", 0, 350, 50, sc);
        end
`endif

        // Death by mid-frame hit and by hit on the tick cycle
        do_reset();
        run_frame(0, 0, 0, 0, 0, GAP);
        run_frame(0, 0, 0, 0, 0, GAP);
        run_frame(0, 0, 0, 1, 0, GAP);
        chk_out("hit_mid", 3, 350, 50, 2);
        run_frame(1, 1, 0, 0, 0, GAP);
        chk_out("dead_frozen", 3, 350, 50, 2);
        run_frame(0, 0, 1, 0, 0, GAP);
        chk_out("restart1", 0, 350, 50, 0);
        run_frame(0, 0, 0, 0, 0, GAP);
        chk_out("run_again", 0, 350, 50, 1);
        run_frame(0, 0, 0, 0, 1, GAP);
        chk_out("hit_tick", 3, 350, 50, 1);
        tone_check("dead_tone", LO, BEEP_FRAMES * GAP + 3, 1'b1);
        chk_out("dead_after_beep", 3, 350, 50, 1);
        run_frame(0, 0, 1, 0, 1, GAP);
        chk_out("hit_beats_start", 3, 350, 50, 1);
        run_frame(0, 0, 1, 0, 0, GAP);
        chk_out("restart2", 0, 350, 50, 0);
        @(negedge clk);
        check("restart2.sound", 32'(bus.sound), 0);

        // Score saturation
        force dut.score_q = 16'hFFFE;
        @(negedge clk);
        release dut.score_q;
        for (int i = 0; i < 3; i++) begin
            run_frame(0, 0, 0, 0, 0, 4);
            chk_out($sformatf("sat%0d", i), 0, 350, 50, 16'hFFFF);
        end

        // Jump beep tone, then asynchronous reset mid-jump and mid-beep
        do_reset();
        run_frame(0, 0, 0, 0, 0, 4);
        run_frame(1, 0, 0, 0, 0, 4);
        chk_out("jump_start", 1, 350, 50, 2);
        tone_check("jump_tone", HI, 2 * HI + 1, 1'b0);
        run_frame(0, 0, 0, 0, 0, 4);
        run_frame(0, 0, 0, 0, 0, 4);
        chk_out("mid_jump", 1, 312, 50, 4);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_reset", 0, 350, 50, 0);
        check("async_reset.sound", 32'(bus.sound), 0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized frames against the model
        do_reset();
        model_reset();
        m_jprev = 1'b0;
        for (int f = 0; f < 300; f++) begin
            bit j, c, s, hm, ht;
            int gap;
            j   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 2) == 0);
            s   = ($urandom_range(0, 1) == 0);
            hm  = ($urandom_range(0, 29) == 0);
            ht  = ($urandom_range(0, 49) == 0);
            gap = $urandom_range(2, 6);
            run_frame(j, c, s, hm, ht, gap);
            model_tick(j, c, s, hm || ht);
            chk_out($sformatf("rnd%0d", f), m_st, m_y, m_hh, m_score);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
